// File: rtl/csa_resolver_if.sv
// Operand/result handshake bundle for csa_resolver.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid and ready are both high.
interface csa_resolver_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] i_s;
    logic [DATA_W-1:0] i_c;
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W:0]   o_sum;
    logic              o_valid;
    logic              i_ready;

    modport master (
        output i_s, i_c, i_valid, i_ready,
        input  o_ready, o_sum, o_valid
    );

    modport slave (
        input  i_s, i_c, i_valid, i_ready,
        output o_ready, o_sum, o_valid
    );
endinterface

// File: rtl/csa_resolver.sv
// Final carry-propagate stage of the CSA tree.
// Resolves a redundant (sum, carry) pair CHUNK_W bits per cycle, carrying between chunks through a register.
module csa_resolver #(
    parameter int DATA_W  = 8,
    parameter int CHUNK_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    csa_resolver_if.slave bus,
    output logic [1:0]    dbg_state
);
    localparam int NCHUNK = (DATA_W + CHUNK_W - 1) / CHUNK_W;
    localparam int PAD_W  = NCHUNK * CHUNK_W;
    localparam int SUM_W  = CHUNK_W + 1;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int IDX_W  = $clog2(SUM_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);
    // Bit of the top chunk's sum that lands on o_sum[DATA_W]; for a partial chunk this is its carry-out.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - (NCHUNK - 1) * CHUNK_W);

    if (CHUNK_W < 1 || CHUNK_W > DATA_W) begin : g_bad_chunk
        $error("csa_resolver: CHUNK_W must be in 1..DATA_W");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [PAD_W-1:0]  s_q;
    logic [PAD_W-1:0]  c_q;
    logic              carry_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W:0]   res_q;
    logic              ready_q;
    logic              valid_q;
    logic [SUM_W-1:0]  chunk_sum;
    logic [DATA_W:0]   res_nxt;

    // Operands shift down one chunk per cycle, so the active chunk is always the low CHUNK_W bits.
    assign chunk_sum = {1'b0, s_q[CHUNK_W-1:0]} + {1'b0, c_q[CHUNK_W-1:0]} + SUM_W'(carry_q);

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
        localparam logic [CNT_W-1:0] K = CNT_W'(gi / CHUNK_W);
        localparam logic [IDX_W-1:0] B = IDX_W'(gi % CHUNK_W);
        assign res_nxt[gi] = (cnt_q == K) ? chunk_sum[B] : res_q[gi];
    end
    assign res_nxt[DATA_W] = (cnt_q == LAST_CNT) ? chunk_sum[LAST_IDX] : res_q[DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            c_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_valid && ready_q) begin
                        s_q     <= PAD_W'(bus.i_s);
                        c_q     <= PAD_W'(bus.i_c);
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= CALC;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                CALC: begin
                    s_q     <= s_q >> CHUNK_W;
                    c_q     <= c_q >> CHUNK_W;
                    carry_q <= chunk_sum[CHUNK_W];
                    res_q   <= res_nxt;
                    if (cnt_q == LAST_CNT) begin
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_sum   = res_q;
    assign dbg_state   = state_q;
endmodule
